// File: rtl/swan256_round_sched.sv
// swan256_round_sched
//   Sequencing controller for the SWAN256 serial datapath. It holds the two
//   128-bit halves {L, R} of a 256-bit block and fetches one 128-bit round key
//   per round over a request/valid handshake. Each round is applied through the
//   internal theta/key-addition stage:
//     L' = R,  R' = L ^ theta(R, rk)
//   The result is returned over a valid/ready handshake.
//
//   Build option: SWAN256_SCHED_FAST_KEY_EN
//     undefined : registered key, KEY -> ROUND, two cycles per round.
//     defined   : the round is applied in the KEY cycle straight from
//                 i_rk_data, one cycle per round, and no key register.
//
// Ports
//   i_clk, i_rst_n            clock, async active-low reset
//   i_in_valid/o_in_ready     input block handshake, i_in_data = {L, R}
//   o_rk_req/o_rk_idx         round key request and round index
//   i_rk_valid/i_rk_data      round key response {c0, c1, c2, c3}
//   o_out_valid/i_out_ready   output handshake, o_out_data = {L, R}
//   o_busy                    high whenever not IDLE
module swan256_round_sched #(
  parameter int BLOCK_SIZE = 256,
  parameter int ROUNDS     = 64,
  parameter int CNT_W      = 7
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [BLOCK_SIZE-1:0]   i_in_data,
  output logic                    o_rk_req,
  output logic [CNT_W-1:0]        o_rk_idx,
  input  logic                    i_rk_valid,
  input  logic [BLOCK_SIZE/2-1:0] i_rk_data,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [BLOCK_SIZE-1:0]   o_out_data,
  output logic                    o_busy
);
  localparam int SIDE_SIZE = BLOCK_SIZE / 2;
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = SIDE_SIZE / NUM_LANES;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_KEY, S_ROUND, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [SIDE_SIZE-1:0] r_L, r_R;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_ld_in, w_round_en, w_cnt_inc;
  logic [SIDE_SIZE-1:0] w_key;

  // Words are MSB-first: packed lane NUM_LANES-1 is a0/c0.
  logic [NUM_LANES-1:0][VEC_W-1:0] w_a, w_c, w_t;

`ifdef SWAN256_SCHED_FAST_KEY_EN
  assign w_key = i_rk_data;
`else
  logic [SIDE_SIZE-1:0] r_rk;
  logic                 w_ld_key;
  assign w_key = r_rk;
`endif

  assign w_a = r_R;
  assign w_c = w_key;

  // Theta lanes: a0 ror 19, a1 ror 9, a2 ror 1, a3 unrotated, each xor its
  // key word. Output is forced to zero unless a round is being applied.
  for (genvar j = 0; j < NUM_LANES; j++) begin : g_theta
    localparam int ROT = (j == 3) ? 19 : (j == 2) ? 9 : (j == 1) ? 1 : 0;
    logic [VEC_W-1:0] w_rot;
    assign w_rot  = (w_a[j] >> ROT) | (w_a[j] << ((VEC_W - ROT) % VEC_W));
    assign w_t[j] = w_round_en ? (w_rot ^ w_c[j]) : '0;
  end

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_in     = 1'b0;
    w_round_en  = 1'b0;
    w_cnt_inc   = 1'b0;
`ifndef SWAN256_SCHED_FAST_KEY_EN
    w_ld_key    = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (i_in_valid) begin
          w_ld_in     = 1'b1;
          w_state_nxt = S_KEY;
        end
      end
      S_KEY: begin
        if (i_rk_valid) begin
`ifdef SWAN256_SCHED_FAST_KEY_EN
          w_round_en = 1'b1;
          if (r_cnt == LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_inc   = 1'b1;
            w_state_nxt = S_KEY;
          end
`else
          w_ld_key    = 1'b1;
          w_state_nxt = S_ROUND;
`endif
        end
      end
      S_ROUND: begin
`ifndef SWAN256_SCHED_FAST_KEY_EN
        w_round_en = 1'b1;
        // Terminal check precedes the increment so cnt never wraps.
        if (r_cnt == LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_inc   = 1'b1;
          w_state_nxt = S_KEY;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
      S_DONE: begin
        if (i_out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_L     <= '0;
      r_R     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_in) begin
        r_L   <= i_in_data[BLOCK_SIZE-1:SIDE_SIZE];
        r_R   <= i_in_data[SIDE_SIZE-1:0];
        r_cnt <= '0;
      end else begin
        if (w_round_en) begin
          r_L <= r_R;
          r_R <= r_L ^ w_t;
        end
        if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifndef SWAN256_SCHED_FAST_KEY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_rk <= '0;
    else if (w_ld_key) r_rk <= i_rk_data;
  end
`endif

  // All outputs are decodes of registered state.
  assign o_in_ready  = (r_state == S_IDLE);
  assign o_rk_req    = (r_state == S_KEY);
  assign o_rk_idx    = r_cnt;
  assign o_out_valid = (r_state == S_DONE);
  assign o_out_data  = (r_state == S_DONE) ? {r_L, r_R} : '0;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_swan256_round_sched.sv
module tb_swan256_round_sched;
  localparam int ROUNDS = 64;
`ifdef SWAN256_SCHED_FAST_KEY_EN
  localparam int LAT_PER = 1;
`else
  localparam int LAT_PER = 2;
`endif

  logic         gclk = 1'b0;
  logic         grst_n = 1'b0;
  always #5 gclk = ~gclk;

  // DUT 0: default ROUNDS
  logic         i_in_valid, o_in_ready, i_rk_valid, o_rk_req, o_out_valid, i_out_ready, o_busy;
  logic [255:0] i_in_data, o_out_data;
  logic [127:0] i_rk_data;
  logic [6:0]   o_rk_idx;
  // DUT 1: ROUNDS=1
  logic         i1_in_valid, o1_in_ready, i1_rk_valid, o1_rk_req, o1_out_valid, i1_out_ready, o1_busy;
  logic [255:0] i1_in_data, o1_out_data;
  logic [127:0] i1_rk_data;
  logic [6:0]   o1_rk_idx;

  swan256_round_sched #(.BLOCK_SIZE(256), .ROUNDS(ROUNDS), .CNT_W(7)) u_dut (
    .i_clk(gclk), .i_rst_n(grst_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_rk_req(o_rk_req), .o_rk_idx(o_rk_idx), .i_rk_valid(i_rk_valid), .i_rk_data(i_rk_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_busy(o_busy));

  swan256_round_sched #(.BLOCK_SIZE(256), .ROUNDS(1), .CNT_W(7)) u_dut1 (
    .i_clk(gclk), .i_rst_n(grst_n),
    .i_in_valid(i1_in_valid), .o_in_ready(o1_in_ready), .i_in_data(i1_in_data),
    .o_rk_req(o1_rk_req), .o_rk_idx(o1_rk_idx), .i_rk_valid(i1_rk_valid), .i_rk_data(i1_rk_data),
    .o_out_valid(o1_out_valid), .i_out_ready(i1_out_ready), .o_out_data(o1_out_data),
    .o_busy(o1_busy));

  int n_chk = 0;
  int n_err = 0;
  logic [127:0] keys [ROUNDS];

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Rotate right in the MSB-first bit view: msb-index i goes to (i+p) mod 32.
  function automatic logic [31:0] ror_msb(input logic [31:0] a, input int p);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o[31 - ((i + p) % 32)] = a[31 - i];
    return o;
  endfunction

  function automatic logic [255:0] ref_enc(input logic [255:0] din, input int nr);
    logic [127:0] l, r, t, nl;
    int rot [4];
    rot = '{19, 9, 1, 0};
    l = din[255:128];
    r = din[127:0];
    for (int k = 0; k < nr; k++) begin
      for (int w = 0; w < 4; w++)
        t[127 - 32*w -: 32] = ror_msb(r[127 - 32*w -: 32], rot[w]) ^ keys[k][127 - 32*w -: 32];
      nl = r;
      r  = l ^ t;
      l  = nl;
    end
    return {l, r};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drive one block through DUT 0. Cycle 0 is the accept cycle.
  task automatic run_block(input logic [255:0] din, input int stall_rnd, input int stall_len,
                           input int bp_len, input int rst_at, output logic [255:0] dout);
    int cyc, rnd, stalled;
    bit done;
    logic [255:0] exp;
    exp = ref_enc(din, ROUNDS);
    dout = '0;
    @(negedge gclk);
    chk("in_ready_idle", {255'b0, o_in_ready}, 256'd1);
    i_in_valid = 1'b1; i_in_data = din; i_rk_valid = 1'b0; i_out_ready = 1'b0;
    cyc = 0; rnd = 0; stalled = 0; done = 1'b0;
    while (!done) begin
      @(negedge gclk);
      cyc++;
      i_in_valid = 1'($urandom_range(0, 1));
      i_in_data  = {rnd128(), rnd128()};
      if (cyc == 1) chk("rk_req_c1", {255'b0, o_rk_req}, 256'd1);
      if (cyc == rst_at) begin
        grst_n = 1'b0;
        #1;
        chk("rst_rk_req", {255'b0, o_rk_req}, 256'd0);
        chk("rst_busy", {255'b0, o_busy}, 256'd0);
        chk("rst_in_ready", {255'b0, o_in_ready}, 256'd1);
        chk("rst_out_valid", {255'b0, o_out_valid}, 256'd0);
        chk("rst_rk_idx", {249'b0, o_rk_idx}, 256'd0);
        chk("rst_out_data", o_out_data, 256'd0);
        i_in_valid = 1'b0; i_rk_valid = 1'b0;
        @(negedge gclk);
        grst_n = 1'b1;
        done = 1'b1;
      end else if (o_out_valid) begin
        chk("latency", cyc, LAT_PER*ROUNDS + 1 + stall_len);
        chk("out_data", o_out_data, exp);
        chk("done_in_ready", {255'b0, o_in_ready}, 256'd0);
        dout = o_out_data;
        for (int k = 0; k < bp_len; k++) begin
          i_out_ready = 1'b0; i_in_valid = 1'b1;
          @(negedge gclk);
          chk("bp_out_valid", {255'b0, o_out_valid}, 256'd1);
          chk("bp_out_data", o_out_data, exp);
          chk("bp_in_ready", {255'b0, o_in_ready}, 256'd0);
        end
        // Handoff cycle with in_valid high: must not be accepted.
        i_out_ready = 1'b1; i_in_valid = 1'b1;
        @(negedge gclk);
        chk("post_out_valid", {255'b0, o_out_valid}, 256'd0);
        chk("post_in_ready", {255'b0, o_in_ready}, 256'd1);
        chk("post_busy", {255'b0, o_busy}, 256'd0);
        i_in_valid = 1'b0; i_out_ready = 1'b0;
        done = 1'b1;
      end else begin
        if (o_rk_req) begin
          chk("rk_idx", {249'b0, o_rk_idx}, rnd);
          if (rnd == stall_rnd && stalled < stall_len) begin
            i_rk_valid = 1'b0; i_rk_data = rnd128(); stalled++;
          end else begin
            i_rk_valid = 1'b1; i_rk_data = keys[rnd]; rnd++;
          end
        end else begin
          i_rk_valid = 1'($urandom_range(0, 1));
          i_rk_data  = rnd128();
        end
        if (cyc > 2000) begin
          chk("timeout", 256'd0, 256'd1);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic run_one_round();
    int cyc;
    bit done;
    @(negedge gclk);
    i1_in_valid = 1'b1;
    i1_in_data  = {128'h0, 128'h00000001_00000001_00000001_00000001};
    i1_rk_valid = 1'b1; i1_rk_data = '0; i1_out_ready = 1'b1;
    cyc = 0; done = 1'b0;
    while (!done) begin
      @(negedge gclk);
      cyc++;
      i1_in_valid = 1'b0;
      if (o1_out_valid) begin
        chk("r1_latency", cyc, LAT_PER + 1);
        chk("r1_out_data", o1_out_data,
            {128'h00000001_00000001_00000001_00000001, 128'h00002000_00800000_80000000_00000001});
        done = 1'b1;
      end else if (cyc > 50) begin
        chk("r1_timeout", 256'd0, 256'd1);
        done = 1'b1;
      end
    end
    @(negedge gclk);
    i1_out_ready = 1'b0;
  endtask

  logic [255:0] d0, d1, din;

  initial begin
    i_in_valid = 0; i_in_data = '0; i_rk_valid = 0; i_rk_data = '0; i_out_ready = 0;
    i1_in_valid = 0; i1_in_data = '0; i1_rk_valid = 0; i1_rk_data = '0; i1_out_ready = 0;
    #12;
    chk("reset_in_ready", {255'b0, o_in_ready}, 256'd1);
    chk("reset_rk_req", {255'b0, o_rk_req}, 256'd0);
    chk("reset_rk_idx", {249'b0, o_rk_idx}, 256'd0);
    chk("reset_out_valid", {255'b0, o_out_valid}, 256'd0);
    chk("reset_out_data", o_out_data, 256'd0);
    chk("reset_busy", {255'b0, o_busy}, 256'd0);
    @(negedge gclk);
    grst_n = 1'b1;

    // All-zero block, zero keys
    for (int k = 0; k < ROUNDS; k++) keys[k] = '0;
    run_block('0, -1, 0, 0, -1, d0);

    // Single round instance
    run_one_round();

    // Random block, then same block with a 5-cycle key stall at round 3
    for (int k = 0; k < ROUNDS; k++) keys[k] = rnd128();
    din = {rnd128(), rnd128()};
    run_block(din, -1, 0, 0, -1, d0);
    run_block(din, 3, 5, 0, -1, d1);
    chk("stall_same_data", d1, d0);

    // Output backpressure for 10 cycles
    din = {rnd128(), rnd128()};
    run_block(din, -1, 0, 10, -1, d0);

    // Reset mid-round, then a fresh block
    run_block(din, -1, 0, 0, 40, d0);
    run_block(din, -1, 0, 0, -1, d0);

    // Random mixes
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < ROUNDS; k++) keys[k] = rnd128();
      din = {rnd128(), rnd128()};
      run_block(din, int'($urandom_range(0, ROUNDS-1)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 3)), -1, d0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
